// File: rtl/start_for_fifo_param.sv
// Shift-register FIFO for HLS start/token and small streaming channels, first-word-fall-through.
// Flags are registered from the next occupancy. Writes while full and reads while empty are dropped.
module start_for_fifo_param #(
  parameter int DATA_WIDTH   = 1,
  parameter int DEPTH        = 2,
  parameter int ADDR_WIDTH   = 1,
  parameter int AFULL_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_write,
  input  logic                  if_write_ce,
  output logic                  if_full_n,
  output logic [DATA_WIDTH-1:0] if_dout,
  input  logic                  if_read,
  input  logic                  if_read_ce,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_count,
  output logic                  if_almost_full
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] sreg_q [DEPTH];
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  empty_n_q, full_n_q, afull_q;
  logic                  wr_acc, rd_acc;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] dout;

  // Accept terms look only at registered flags, so a full FIFO never takes a write
  // even when a read frees a slot in the same cycle.
  assign wr_acc = if_write & if_write_ce & full_n_q;
  assign rd_acc = if_read  & if_read_ce  & empty_n_q;

  always_comb begin
    count_d = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + ONE_C;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - ONE_C;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count_q   <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
      afull_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      empty_n_q <= (count_d != '0);
      full_n_q  <= (count_d != DEPTH_C);
      afull_q   <= (count_d >= AFULL_C);
    end
  end

  // Data registers carry no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        sreg_q[i] <= sreg_q[i-1];
      end
      sreg_q[0] <= if_din;
    end
  end

  assign rd_addr = (count_q == '0) ? '0 : ADDR_WIDTH'(count_q - ONE_C);

  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == ADDR_WIDTH'(i)) begin
        dout = sreg_q[i];
      end
    end
  end

  assign if_dout        = dout;
  assign if_count       = count_q;
  assign if_empty_n     = empty_n_q;
  assign if_full_n      = full_n_q;
  assign if_almost_full = afull_q;

endmodule

// File: tb/tb_start_for_fifo_param.sv
// Bench for start_for_fifo_param: directed table on DEPTH=4, hand sequence on DEPTH=1, random vs queue model.
module tb_start_for_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic       reset, flush, wr, wce, rd, rce;
  logic [7:0] din, dout;
  logic       full_n, empty_n, afull;
  logic [2:0] count;

  start_for_fifo_param #(.DATA_WIDTH(8), .DEPTH(4), .ADDR_WIDTH(2), .AFULL_THRESH(3)) u_dut4 (
    .clk(clk), .reset(reset), .flush(flush),
    .if_din(din), .if_write(wr), .if_write_ce(wce), .if_full_n(full_n),
    .if_dout(dout), .if_read(rd), .if_read_ce(rce), .if_empty_n(empty_n),
    .if_count(count), .if_almost_full(afull)
  );

  // DEPTH=1 instance
  logic       reset1, flush1, wr1, wce1, rd1, rce1;
  logic [3:0] din1, dout1;
  logic       full_n1, empty_n1, afull1;
  logic [1:0] count1;

  start_for_fifo_param #(.DATA_WIDTH(4), .DEPTH(1), .ADDR_WIDTH(1), .AFULL_THRESH(1)) u_dut1 (
    .clk(clk), .reset(reset1), .flush(flush1),
    .if_din(din1), .if_write(wr1), .if_write_ce(wce1), .if_full_n(full_n1),
    .if_dout(dout1), .if_read(rd1), .if_read_ce(rce1), .if_empty_n(empty_n1),
    .if_count(count1), .if_almost_full(afull1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       fl, w, wc;
    logic [7:0] d;
    logic       r, rc;
    int         cnt;
    logic       en, fn, af;
    logic       chkd;
    logic [7:0] dq;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic fl, logic w, logic wc, logic [7:0] d, logic r, logic rc,
                              int cnt, logic en, logic fn, logic af, logic chkd, logic [7:0] dq);
    vec_t v;
    v.fl = fl; v.w = w; v.wc = wc; v.d = d; v.r = r; v.rc = rc;
    v.cnt = cnt; v.en = en; v.fn = fn; v.af = af; v.chkd = chkd; v.dq = dq;
    return v;
  endfunction

  task automatic step4(input logic fl, input logic w, input logic wc, input logic [7:0] d,
                       input logic r, input logic rc);
    flush = fl; wr = w; wce = wc; din = d; rd = r; rce = rc;
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input logic rs, input logic w, input logic [3:0] d, input logic r);
    reset1 = rs; wr1 = w; din1 = d; rd1 = r;
    @(posedge clk);
    #1;
  endtask

  int q[$];

  initial begin
    reset = 1'b1; flush = 1'b0; wr = 1'b0; wce = 1'b1; rd = 1'b0; rce = 1'b1; din = '0;
    reset1 = 1'b1; flush1 = 1'b0; wr1 = 1'b0; wce1 = 1'b1; rd1 = 1'b0; rce1 = 1'b1; din1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst4_empty_n", empty_n, 0);
    chk("rst4_full_n",  full_n,  1);
    chk("rst4_count",   count,   0);
    chk("rst4_afull",   afull,   0);
    chk("rst1_empty_n", empty_n1, 0);
    chk("rst1_full_n",  full_n1,  1);
    reset = 1'b0; reset1 = 1'b0;

    // fill to full, overflow attempt, drain
    vt.push_back(mk(0,1,1,8'h11,0,1, 1,1,1,0, 1,8'h11));
    vt.push_back(mk(0,1,1,8'h22,0,1, 2,1,1,0, 1,8'h11));
    vt.push_back(mk(0,1,1,8'h33,0,1, 3,1,1,1, 1,8'h11));
    vt.push_back(mk(0,1,1,8'h44,0,1, 4,1,0,1, 1,8'h11));
    vt.push_back(mk(0,1,1,8'h55,0,1, 4,1,0,1, 1,8'h11));
    vt.push_back(mk(0,0,1,8'h00,1,1, 3,1,1,1, 1,8'h22));
    vt.push_back(mk(0,0,1,8'h00,1,1, 2,1,1,0, 1,8'h33));
    vt.push_back(mk(0,0,1,8'h00,1,1, 1,1,1,0, 1,8'h44));
    vt.push_back(mk(0,0,1,8'h00,1,1, 0,0,1,0, 0,8'h00));
    // steady-state streaming at count=2
    vt.push_back(mk(0,1,1,8'hA0,0,1, 1,1,1,0, 1,8'hA0));
    vt.push_back(mk(0,1,1,8'hA1,0,1, 2,1,1,0, 1,8'hA0));
    for (int k = 0; k < 8; k++)
      vt.push_back(mk(0,1,1,8'hA2 + 8'(k),1,1, 2,1,1,0, 1,8'hA1 + 8'(k)));
    // full with simultaneous read/write: write dropped
    vt.push_back(mk(0,1,1,8'hAA,0,1, 3,1,1,1, 1,8'hA8));
    vt.push_back(mk(0,1,1,8'hAB,0,1, 4,1,0,1, 1,8'hA8));
    vt.push_back(mk(0,1,1,8'hCC,1,1, 3,1,1,1, 1,8'hA9));
    vt.push_back(mk(0,0,1,8'h00,1,1, 2,1,1,0, 1,8'hAA));
    vt.push_back(mk(0,0,1,8'h00,1,1, 1,1,1,0, 1,8'hAB));
    vt.push_back(mk(0,0,1,8'h00,1,1, 0,0,1,0, 0,8'h00));
    // empty with simultaneous read/write: read ignored
    vt.push_back(mk(0,1,1,8'h5B,1,1, 1,1,1,0, 1,8'h5B));
    vt.push_back(mk(0,1,1,8'h01,0,1, 2,1,1,0, 1,8'h5B));
    // flush beats a concurrent write
    vt.push_back(mk(0,1,1,8'h02,0,1, 3,1,1,1, 1,8'h5B));
    vt.push_back(mk(1,1,1,8'h77,0,1, 0,0,1,0, 0,8'h00));
    vt.push_back(mk(0,1,1,8'h5A,0,1, 1,1,1,0, 1,8'h5A));
    // clock-enables gate requests
    vt.push_back(mk(0,1,0,8'h66,0,1, 1,1,1,0, 1,8'h5A));
    vt.push_back(mk(0,0,1,8'h00,1,0, 1,1,1,0, 1,8'h5A));
    vt.push_back(mk(0,0,1,8'h00,1,1, 0,0,1,0, 0,8'h00));

    foreach (vt[i]) begin
      step4(vt[i].fl, vt[i].w, vt[i].wc, vt[i].d, vt[i].r, vt[i].rc);
      chk($sformatf("vec%0d_count", i),   count,   vt[i].cnt);
      chk($sformatf("vec%0d_empty_n", i), empty_n, vt[i].en);
      chk($sformatf("vec%0d_full_n", i),  full_n,  vt[i].fn);
      chk($sformatf("vec%0d_afull", i),   afull,   vt[i].af);
      if (vt[i].chkd) chk($sformatf("vec%0d_dout", i), dout, vt[i].dq);
    end

    // DEPTH=1 corner cases, including reset mid-operation
    step1(0, 1, 4'h7, 0);
    chk("d1_w_full_n",  full_n1,  0);
    chk("d1_w_empty_n", empty_n1, 1);
    chk("d1_w_afull",   afull1,   1);
    chk("d1_w_dout",    dout1,    4'h7);
    step1(0, 1, 4'h9, 0);
    chk("d1_w2_count",  count1,   1);
    chk("d1_w2_dout",   dout1,    4'h7);
    step1(0, 0, 4'h0, 1);
    chk("d1_r_full_n",  full_n1,  1);
    chk("d1_r_empty_n", empty_n1, 0);
    step1(0, 1, 4'h3, 0);
    chk("d1_w3_full_n", full_n1,  0);
    step1(1, 1, 4'h5, 0);
    chk("d1_rst_full_n",  full_n1,  1);
    chk("d1_rst_empty_n", empty_n1, 0);
    chk("d1_rst_count",   count1,   0);
    chk("d1_rst_afull",   afull1,   0);
    step1(0, 0, 4'h0, 0);

    // randomized traffic on DEPTH=4 against a queue model
    q.delete();
    for (int c = 0; c < 600; c++) begin
      logic fl, w, wc, r, rc, wa, ra;
      logic [7:0] d;
      int wbias;
      wbias = (c < 300) ? 3 : 1;
      fl = ($urandom_range(0, 31) == 0);
      w  = ($urandom_range(0, 3) < wbias);
      wc = ($urandom_range(0, 7) != 0);
      r  = ($urandom_range(0, 3) >= wbias);
      r  = r | ($urandom_range(0, 3) == 0);
      rc = ($urandom_range(0, 7) != 0);
      d  = 8'($urandom);
      wa = w && wc && (q.size() < 4);
      ra = r && rc && (q.size() > 0);
      step4(fl, w, wc, d, r, rc);
      if (fl) begin
        q.delete();
      end else begin
        if (ra) void'(q.pop_front());
        if (wa) q.push_back(int'(d));
      end
      chk("rnd_count",   count,   q.size());
      chk("rnd_empty_n", empty_n, int'(q.size() != 0));
      chk("rnd_full_n",  full_n,  int'(q.size() != 4));
      chk("rnd_afull",   afull,   int'(q.size() >= 3));
      if (q.size() > 0) chk("rnd_dout", dout, q[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/start_for_fifo_param.md
# start_for_fifo_param

Parametrised shift-register FIFO for dataflow start/token channels between HLS processes. It is the generalised successor of the fixed two-deep start FIFO. It adds arbitrary depth, an occupancy count, a programmable almost-full flag and a synchronous flush. It sits between a producer process's start/done token output and the consumer's start input, and it also serves as a small data FIFO on streaming channels.

## Interface
- DATA_WIDTH, 1, width of each stored word
- DEPTH, 2, number of entries; legal range 1..64
- ADDR_WIDTH, 1, ceil(log2(DEPTH)), minimum 1
- AFULL_THRESH, 1, occupancy at or above which if_almost_full asserts; legal range 1..DEPTH

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  reset, synchronous, active-high
- flush  in  1  synchronous clear of contents; no effect on data registers
- if_din  in  DATA_WIDTH  write data
- if_write  in  1  write request
- if_write_ce  in  1  write clock-enable; a write occurs only when if_write & if_write_ce & if_full_n
- if_full_n  out  1  1 = space available
- if_dout  out  DATA_WIDTH  head-of-queue data, first-word-fall-through
- if_read  in  1  read request
- if_read_ce  in  1  read clock-enable; a read occurs only when if_read & if_read_ce & if_empty_n
- if_empty_n  out  1  1 = data available
- if_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- if_almost_full  out  1  registered, equals (if_count >= AFULL_THRESH)

## Operation
- Storage: sreg[0..DEPTH-1]. On a write, every entry shifts up one (sreg[i] <= sreg[i-1]) and sreg[0] <= if_din. This is gated by the write-accept term only.
- Read address: rd_addr = count-1 when count > 0, else 0. if_dout = sreg[rd_addr], combinational from registers.
- Occupancy count, ADDR_WIDTH+1 bits, unsigned:
  - write only: count + 1
  - read only: count - 1
  - write and read together: count unchanged
  - neither: count unchanged
- Flags are registered from the next count value:
  - if_empty_n = (next count != 0)
  - if_full_n = (next count != DEPTH)
  - if_almost_full = (next count >= AFULL_THRESH)
- Accept terms use the registered flags, so a write while full is dropped, even if a read happens in the same cycle. A read while empty is ignored, even if a write happens in the same cycle.
- Priority: reset > flush > normal operation. Flush sets count 0, if_empty_n 0, if_full_n 1, if_almost_full 0. A write or read in the flush cycle is discarded.
- DEPTH=1: if_full_n and if_empty_n are complementary. A simultaneous read and write cannot occur.
- Illegal states are not reachable. The count never exceeds DEPTH and never underflows.

## Timing
- Reset values: if_empty_n 0, if_full_n 1, if_count 0, if_almost_full 0. if_dout is don't-care until the first write.
- Write latency: a write accepted at edge t makes if_empty_n 1 after t, with the word on if_dout in the same cycle if the FIFO was empty.
- Read latency: a read accepted at edge t presents the next word on if_dout after t. There are zero bubble cycles for back-to-back reads.
- Sustained throughput is one word per cycle with simultaneous read and write at any occupancy from 1 to DEPTH-1.
- Reset or flush asserted mid-transfer takes effect at that edge. Prior contents are lost and no partial state persists.

## Test plan
- Reset, DEPTH=4, DATA_WIDTH=8 -> if_empty_n=0, if_full_n=1, if_count=0, if_almost_full=0.
- Write 0x11, 0x22, 0x33, 0x44 on consecutive cycles, AFULL_THRESH=3:
  - if_count steps 1..4; if_almost_full rises after the 3rd write; if_full_n=0 after the 4th.
  - A 5th write of 0x55 is dropped and if_count stays 4.
  - Then read four times: if_dout 0x11, 0x22, 0x33, 0x44 on consecutive cycles, with if_empty_n=0 after the last read.
- Hold if_count=2 with contents 0xA0, 0xA1. Assert read and write (0xA2..0xA9) together for 8 cycles -> if_count stays 2 and if_dout reads 0xA0..0xA7 in order.
- Full FIFO, read and write asserted together -> the read is accepted, the write is dropped, if_count goes to 3 and if_full_n goes to 1. Empty FIFO, read and write together -> if_count goes to 1 and the written word appears on if_dout.
- Count=3 with flush and write asserted together -> if_count=0, if_empty_n=0, if_full_n=1 next cycle. A subsequent single write 0x5A makes if_dout=0x5A.
- DEPTH=1:
  - Write 0x7 gives if_full_n=0 and if_empty_n=1.
  - A further write is ignored.
  - A read gives if_full_n=1 and if_empty_n=0.
  - Assert reset mid-operation: flags return to their reset values.
